// File: rtl/plate_search_sequencer.sv
// plate_search_sequencer
// Frame-level controller for the plate detector. It sweeps two mirrored
// search windows across the frame, latches the candidate box the detector
// reports, and measures Sobel edge density inside that box for one frame.
// A dense enough box is locked (display frozen to the crop) for a fixed
// number of frames. Otherwise the sweep resumes where it left off.

module plate_search_sequencer #(
    parameter int H_TOTAL     = 800,
    parameter int WIN_W       = 270,
    parameter int STEP        = 5,
    parameter int EDGE_THRESH = 7300,
    parameter int LOCK_FRAMES = 60,
    parameter int CNT_W       = 15
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iEnable,
    input  logic              iFrameStart,
    input  logic [12:0]       iH_Cont,
    input  logic [12:0]       iV_Cont,
    input  logic              iFound,
    input  logic              iFoundSide,
    input  logic [12:0]       iFoundX1,
    input  logic [12:0]       iFoundY1,
    input  logic [12:0]       iFoundX2,
    input  logic [12:0]       iFoundY2,
    input  logic              iEdge,
    output logic              oSearchEn,
    output logic [12:0]       oWinL_X1,
    output logic [12:0]       oWinL_X2,
    output logic [12:0]       oWinR_X1,
    output logic [12:0]       oWinR_X2,
    output logic [12:0]       oBoxX1,
    output logic [12:0]       oBoxY1,
    output logic [12:0]       oBoxX2,
    output logic [12:0]       oBoxY2,
    output logic              oBoxSide,
    output logic              oBoxValid,
    output logic              oFreeze,
    output logic [1:0]        oState,
    output logic [CNT_W-1:0]  oEdgeCount
);

    localparam int LOCK_W = $clog2(LOCK_FRAMES + 1);

    localparam logic [12:0] L_X1_RST = 13'd0;
    localparam logic [12:0] L_X2_RST = 13'(WIN_W);
    localparam logic [12:0] R_X1_RST = 13'(H_TOTAL);
    localparam logic [12:0] R_X2_RST = 13'(H_TOTAL - WIN_W);
    localparam logic [12:0] STEP13   = 13'(STEP);
    localparam logic [31:0] THRESH32 = 32'(EDGE_THRESH);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEARCH   = 2'd1,
        VALIDATE = 2'd2,
        LOCK     = 2'd3
    } stateType;

    stateType          state, stateNxt;
    logic [12:0]       winLX1Nxt, winLX2Nxt, winRX1Nxt, winRX2Nxt;
    logic [12:0]       boxX1Nxt, boxY1Nxt, boxX2Nxt, boxY2Nxt;
    logic              boxSideNxt;
    logic [CNT_W-1:0]  edgeCnt, edgeCntNxt;
    logic [CNT_W-1:0]  edgeCountNxt;
    logic              counting, countingNxt;
    logic [LOCK_W-1:0] lockCnt, lockCntNxt;
    logic              reloadWin, stepWin;
    logic              inBox;

    // Raster position lies inside the latched box; a degenerate box never matches
    always_comb begin
        inBox = (iH_Cont >= oBoxX1) && (iH_Cont <= oBoxX2) &&
                (iV_Cont >= oBoxY1) && (iV_Cont <= oBoxY2);
    end

    // Next-state and next-register computation for the whole sequencer
    always_comb begin
        stateNxt     = state;
        boxX1Nxt     = oBoxX1;
        boxY1Nxt     = oBoxY1;
        boxX2Nxt     = oBoxX2;
        boxY2Nxt     = oBoxY2;
        boxSideNxt   = oBoxSide;
        edgeCntNxt   = edgeCnt;
        edgeCountNxt = oEdgeCount;
        countingNxt  = counting;
        lockCntNxt   = lockCnt;
        reloadWin    = 1'b0;
        stepWin      = 1'b0;

        if (!iEnable) begin
            stateNxt    = IDLE;
            reloadWin   = 1'b1;
            boxX1Nxt    = 13'd0;
            boxY1Nxt    = 13'd0;
            boxX2Nxt    = 13'd0;
            boxY2Nxt    = 13'd0;
            boxSideNxt  = 1'b0;
            edgeCntNxt  = '0;
            countingNxt = 1'b0;
            lockCntNxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (iFrameStart) begin
                        stateNxt = SEARCH;
                    end
                end
                SEARCH: begin
                    if (iFound) begin
                        stateNxt    = VALIDATE;
                        boxX1Nxt    = iFoundX1;
                        boxY1Nxt    = iFoundY1;
                        boxX2Nxt    = iFoundX2;
                        boxY2Nxt    = iFoundY2;
                        boxSideNxt  = iFoundSide;
                        countingNxt = 1'b0;
                    end else if (iFrameStart) begin
                        if (oWinL_X1 >= oWinR_X2) begin
                            reloadWin = 1'b1;
                        end else begin
                            stepWin = 1'b1;
                        end
                    end
                end
                VALIDATE: begin
                    if (!counting) begin
                        if (iFrameStart) begin
                            edgeCntNxt  = '0;
                            countingNxt = 1'b1;
                        end
                    end else if (iFrameStart) begin
                        edgeCountNxt = edgeCnt;
                        countingNxt  = 1'b0;
                        if (32'(edgeCnt) > THRESH32) begin
                            stateNxt   = LOCK;
                            lockCntNxt = '0;
                        end else begin
                            stateNxt = SEARCH;
                        end
                    end else if (iEdge && inBox && (edgeCnt != '1)) begin
                        edgeCntNxt = edgeCnt + CNT_W'(1);
                    end
                end
                LOCK: begin
                    if (iFrameStart) begin
                        if (lockCnt == LOCK_LAST) begin
                            stateNxt   = SEARCH;
                            reloadWin  = 1'b1;
                            lockCntNxt = '0;
                        end else begin
                            lockCntNxt = lockCnt + LOCK_W'(1);
                        end
                    end
                end
                default: begin
                    stateNxt = IDLE;
                end
            endcase
        end

        winLX1Nxt = oWinL_X1;
        winLX2Nxt = oWinL_X2;
        winRX1Nxt = oWinR_X1;
        winRX2Nxt = oWinR_X2;
        if (reloadWin) begin
            winLX1Nxt = L_X1_RST;
            winLX2Nxt = L_X2_RST;
            winRX1Nxt = R_X1_RST;
            winRX2Nxt = R_X2_RST;
        end else if (stepWin) begin
            winLX1Nxt = oWinL_X1 + STEP13;
            winLX2Nxt = oWinL_X2 + STEP13;
            winRX1Nxt = oWinR_X1 - STEP13;
            winRX2Nxt = oWinR_X2 - STEP13;
        end
    end

    // Register every output and internal counter; reset restores rest positions
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state      <= IDLE;
            oWinL_X1   <= L_X1_RST;
            oWinL_X2   <= L_X2_RST;
            oWinR_X1   <= R_X1_RST;
            oWinR_X2   <= R_X2_RST;
            oBoxX1     <= 13'd0;
            oBoxY1     <= 13'd0;
            oBoxX2     <= 13'd0;
            oBoxY2     <= 13'd0;
            oBoxSide   <= 1'b0;
            oBoxValid  <= 1'b0;
            oFreeze    <= 1'b0;
            oSearchEn  <= 1'b0;
            oEdgeCount <= '0;
            edgeCnt    <= '0;
            counting   <= 1'b0;
            lockCnt    <= '0;
        end else begin
            state      <= stateNxt;
            oWinL_X1   <= winLX1Nxt;
            oWinL_X2   <= winLX2Nxt;
            oWinR_X1   <= winRX1Nxt;
            oWinR_X2   <= winRX2Nxt;
            oBoxX1     <= boxX1Nxt;
            oBoxY1     <= boxY1Nxt;
            oBoxX2     <= boxX2Nxt;
            oBoxY2     <= boxY2Nxt;
            oBoxSide   <= boxSideNxt;
            oBoxValid  <= (stateNxt == LOCK);
            oFreeze    <= (stateNxt == LOCK);
            oSearchEn  <= (stateNxt == SEARCH);
            oEdgeCount <= edgeCountNxt;
            edgeCnt    <= edgeCntNxt;
            counting   <= countingNxt;
            lockCnt    <= lockCntNxt;
        end
    end

    // State is exposed directly as its encoding
    always_comb begin
        oState = state;
    end

endmodule

// File: doc/plate_search_sequencer.md
# plate_search_sequencer

Frame-level controller for the plate-detection datapath in the VGA output path. It schedules the two mirrored search windows (left sweeping right, right sweeping left) that the morphological detector scans and latches the candidate box the detector reports. It runs a one-frame Sobel edge-density check on that box, then either locks the box (freezing the display to the crop) or resumes the sweep. It sits between the VGA timing counters and the overlay mux, and consumes the same H/V counts.

## Interface
- H_TOTAL, 800, horizontal count span; right window reload edge
- WIN_W, 270, search window width in pixels
- STEP, 5, window shift per frame in pixels
- EDGE_THRESH, 7300, edge count must be strictly greater than this to validate
- LOCK_FRAMES, 60, frames held in LOCK before the search restarts
- CNT_W, 15, edge counter width
- iCLK  in  1  pixel clock; the block's only clock
- iRST  in  1  synchronous reset, active-high
- iEnable  in  1  search mode enable (level)
- iFrameStart  in  1  one-cycle pulse when V_Cont==0 and H_Cont==0
- iH_Cont, iV_Cont  in  13 each  current raster position
- iFound  in  1  one-cycle pulse: detector has a candidate
- iFoundSide  in  1  0 = left window, 1 = right window; qualified by iFound
- iFoundX1, iFoundY1, iFoundX2, iFoundY2  in  13 each  candidate box, inclusive; qualified by iFound
- iEdge  in  1  Sobel pixel saturated (all ones) at current raster position
- oSearchEn  out  1  detector may scan
- oWinL_X1, oWinL_X2, oWinR_X1, oWinR_X2  out  13 each  window bounds, inclusive
- oBoxX1, oBoxY1, oBoxX2, oBoxY2  out  13 each  latched box
- oBoxSide  out  1  side of latched box
- oBoxValid  out  1  box validated; overlay should show the crop
- oFreeze  out  1  camera capture freeze request
- oState  out  2  0 IDLE, 1 SEARCH, 2 VALIDATE, 3 LOCK
- oEdgeCount  out  CNT_W  last completed validation count

All outputs are registered. Reset values: every output is 0, except oWinL_X2 = WIN_W, oWinR_X1 = H_TOTAL, and oWinR_X2 = H_TOTAL−WIN_W.

## Operation
- **Priority:** iEnable low forces IDLE on the next edge from any state. Windows reload; the box, the counter and oBoxValid clear. Only oEdgeCount keeps its value.
- **IDLE:** oSearchEn=0. Goes to SEARCH on iFrameStart while iEnable=1.
- **SEARCH:** oSearchEn=1.
  - On each iFrameStart, the left window moves +STEP on both bounds and the right window moves −STEP on both bounds.
  - If the current oWinL_X1 ≥ oWinR_X2 (windows crossed), the step is replaced by a reload to the reset positions.
  - On iFound, latch the box and side, then go to VALIDATE.
  - If iFound and iFrameStart arrive in the same cycle, iFound wins and the windows do not step.
- **VALIDATE:** oSearchEn=0; iFound is ignored.
  - Sub-phase ARM: wait for iFrameStart; it clears the counter and starts COUNT.
  - Sub-phase COUNT: each cycle with iEdge=1 and the raster inside the box (X1≤H≤X2, Y1≤V≤Y2) increments the counter. The counter saturates at 2^CNT_W−1.
  - At the next iFrameStart: oEdgeCount ← count. If count > EDGE_THRESH, go to LOCK; otherwise go to SEARCH with the windows unchanged (no step on that pulse).
  - A degenerate box (X1>X2 or Y1>Y2) counts nothing and fails.
- **LOCK:** oBoxValid=1 and oFreeze=1.
  - A frame counter increments on each iFrameStart.
  - When it reaches LOCK_FRAMES, go to SEARCH: windows reload, oBoxValid and oFreeze clear, the counter clears.
- **Width rules:** all window arithmetic is 13-bit unsigned. The cross check prevents underflow of the right window.

## Timing
- oState, the windows and the flags update on the edge after the triggering input, so latency is 1 cycle.
- The box is latched on the same edge that enters VALIDATE; oBox* is valid from that cycle.
- The cycle carrying the iFrameStart that starts COUNT is not counted. The cycle carrying the closing iFrameStart is not counted.
- oEdgeCount updates on the same edge as the VALIDATE exit transition.
- A minimum VALIDATE residency is ARM wait plus one full frame: V_TOTAL·(H_TOTAL+1) cycles with 525/801 timing.
- iRST mid-frame returns every output to its reset value on the next edge; sequencing resumes at the next iFrameStart.

## Test plan
- Reset, iEnable=1, 3 frames with no iFound:
  - oState goes 0→1.
  - After three iFrameStart pulses, WinL = 15..285 and WinR = 785..515.
- Sweep crossing: drive frames until WinL_X1 ≥ WinR_X2 (crossing at the 53rd pulse, i.e. WinL_X1=265 vs WinR_X2=265). The next iFrameStart reloads to 0/270/800/530.
- iFound with side=1 and box (600,200)-(700,240):
  - oState=2 next cycle; oBox* and oBoxSide match the inputs.
  - Assert iEdge on 4141 pixels inside the box during the COUNT frame → oEdgeCount=4141 and oState=1, windows unchanged.
- Same box with iEdge=1 on every box pixel (101·41=4141 → fail). Repeat with box (100,100)-(300,140): 201·41=8241 > 7300 → LOCK, oBoxValid=1, oFreeze=1. After 60 frames → SEARCH with windows reloaded.
- Simultaneous iFound and iFrameStart in SEARCH → VALIDATE entered, windows not stepped. iFound during VALIDATE → box unchanged.
- Drop iEnable during LOCK → next cycle oState=0, oFreeze=0, oBoxValid=0. Pulse iRST mid-COUNT → all outputs at reset values next cycle.
